// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one single-port synchronous RAM (one-cycle read latency) among
// three requesters: data load/store, instruction fetch and VGA framebuffer
// reads. Every granted request runs the same four-state sequence
// IDLE -> ACCESS -> RESP -> ACK. Fixed priority data > fetch > VGA, with a
// starvation guard that hands the port to VGA after VGA_MAX_WAIT lost grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int VGA_MAX_WAIT = 4     // legal range 1..15
) (
    input  logic              clock,
    input  logic              reset,

    // data load/store port
    input  logic              dat_req,
    input  logic              dat_we,
    input  logic [ADDR_W-1:0] dat_addr,
    input  logic [DATA_W-1:0] dat_wdata,
    output logic              dat_ack,
    output logic [DATA_W-1:0] dat_rdata,

    // instruction fetch port (read only)
    input  logic              fet_req,
    input  logic [ADDR_W-1:0] fet_addr,
    output logic              fet_ack,
    output logic [DATA_W-1:0] fet_rdata,

    // VGA framebuffer port (read only)
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,

    // RAM macro side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // ------------------------------------------------------------------
    // State encoding and requester ids
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [1:0] ID_DAT = 2'd0;
    localparam logic [1:0] ID_FET = 2'd1;
    localparam logic [1:0] ID_VGA = 2'd2;

    // Threshold at which a waiting VGA request overrides fixed priority.
    localparam logic [3:0] WAIT_MAX = 4'(VGA_MAX_WAIT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [1:0]        gnt_id;     // which port owns the current transaction
    logic [ADDR_W-1:0] gnt_addr;   // captured at grant, immune to req/addr changes
    logic              gnt_we;
    logic [DATA_W-1:0] gnt_wdata;
    logic [3:0]        vga_wait;   // lost arbitrations while VGA was requesting

    // ------------------------------------------------------------------
    // Arbitration result for the current IDLE cycle
    // ------------------------------------------------------------------
    logic              any_req;
    logic              vga_promote;
    logic [1:0]        win_id;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic [DATA_W-1:0] win_wdata;

    // Pick the winner and mux its request fields; only consumed in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if/case chain leaves a value unassigned (no latches).
        any_req     = dat_req | fet_req | vga_req;
        vga_promote = vga_req && (vga_wait == WAIT_MAX);
        win_id      = ID_DAT;
        win_addr    = dat_addr;
        win_we      = 1'b0;
        win_wdata   = '0;

        if (vga_promote) begin
            win_id = ID_VGA;
        end else if (dat_req) begin
            win_id = ID_DAT;
        end else if (fet_req) begin
            win_id = ID_FET;
        end else if (vga_req) begin
            win_id = ID_VGA;
        end

        case (win_id)
            ID_DAT: begin
                win_addr  = dat_addr;
                win_we    = dat_we;
                win_wdata = dat_wdata;
            end
            ID_FET: win_addr = fet_addr;
            ID_VGA: win_addr = vga_addr;
            default: win_addr = dat_addr;
        endcase
    end

    // Main sequencer: fixed four-cycle walk once a request is granted.
    always_ff @(posedge clock) begin
        // NOTE: state updates use non-blocking assignments so every register
        // in the design samples pre-edge values, independent of block order.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (any_req) state <= S_ACCESS;
                S_ACCESS: state <= S_RESP;
                S_RESP:   state <= S_ACK;
                S_ACK:    state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Capture the winner's request at grant time; the RAM address/data
    // outputs come straight from here, so they hold between transactions.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_id    <= ID_DAT;
            gnt_addr  <= '0;
            gnt_we    <= 1'b0;
            gnt_wdata <= '0;
        end else if (state == S_IDLE && any_req) begin
            gnt_id    <= win_id;
            gnt_addr  <= win_addr;
            gnt_we    <= win_we;
            gnt_wdata <= win_wdata;
        end
    end

    // Starvation counter: count VGA losses, clear on a VGA grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_wait <= '0;
        end else if (state == S_IDLE && any_req) begin
            if (win_id == ID_VGA) begin
                vga_wait <= '0;
            end else if (vga_req && vga_wait < WAIT_MAX) begin
                vga_wait <= vga_wait + 4'd1;
            end
        end
    end

    // Read-data holding registers: only the granted port's register loads,
    // and only on a read, at the end of RESP when the RAM output is valid.
    always_ff @(posedge clock) begin
        // NOTE: these are plain registers, not a memory array, and their
        // post-reset value is visible on the ports, so they are reset.
        if (reset) begin
            dat_rdata <= '0;
            fet_rdata <= '0;
            vga_rdata <= '0;
        end else if (state == S_RESP && !gnt_we) begin
            case (gnt_id)
                ID_DAT:  dat_rdata <= mem_rdata;
                ID_FET:  fet_rdata <= mem_rdata;
                ID_VGA:  vga_rdata <= mem_rdata;
                default: dat_rdata <= dat_rdata;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state (no input-to-output paths)
    // ------------------------------------------------------------------
    assign mem_addr  = gnt_addr;
    assign mem_wdata = gnt_wdata;
    assign mem_we    = (state == S_ACCESS) && gnt_we;

    assign dat_ack   = (state == S_ACK) && (gnt_id == ID_DAT);
    assign fet_ack   = (state == S_ACK) && (gnt_id == ID_FET);
    assign vga_ack   = (state == S_ACK) && (gnt_id == ID_VGA);

    assign busy      = (state != S_IDLE);

endmodule
